// File: rtl/rr_hold_arbiter_pkg.sv
// rr_hold_arbiter_pkg: shared FSM state encoding for the round-robin arbiters
package rr_hold_arbiter_pkg;
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;
endpackage

// File: rtl/rr_hold_arbiter_if.sv
// rr_hold_arbiter_if: request/grant bundle between requesters (master) and arbiter (slave)
interface rr_hold_arbiter_if #(parameter int N = 4) ();
  logic [N-1:0]         req;
  logic [N-1:0]         grant;
  logic [$clog2(N)-1:0] grant_id;
  logic                 busy;
  modport master (output req, input grant, grant_id, busy);
  modport slave (input req, output grant, grant_id, busy);
endinterface

// File: rtl/rr_hold_arbiter_pick.sv
// rr_pick: combinational rotating priority encoder, first set req at ptr, ptr+1, ... wrapping mod N
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 any,
  output logic [$clog2(N)-1:0] idx
);
  localparam int W = $clog2(N);
  logic [W-1:0] j;
  // descending scan so the candidate closest to ptr is written last and wins
  always_comb begin
    any = |req;
    idx = '0;
    j   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = W'((int'(ptr) + i) % N);
      if (req[j]) idx = j;
    end
  end
endmodule

// File: rtl/rr_hold_arbiter.sv
// rr_hold_arbiter: fair round-robin arbiter with held grants; optional hold limit via RR_ARB_HOLD_LIMIT_EN
module rr_hold_arbiter
  import rr_hold_arbiter_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input logic               clk,
  input logic               reset,
  rr_hold_arbiter_if.slave  bus
);
  localparam int W = $clog2(N);
  state_t       state_q, state_d;
  logic [W-1:0] owner_q, owner_d, ptr_q, ptr_d, pick_idx;
  logic [N-1:0] pick_req;
  logic         pick_any, keep;
  function automatic logic [W-1:0] wrap_inc(input logic [W-1:0] i);
    return (i == W'(N - 1)) ? '0 : i + 1'b1;
  endfunction
  // the current owner never competes, so release and revoke both hand over to someone else
  assign pick_req = (state_q == ST_GRANT) ? bus.req & ~(N'(1) << owner_q) : bus.req;
  rr_pick #(.N(N)) u_pick (
    .req (pick_req),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );
`ifdef RR_ARB_HOLD_LIMIT_EN
  localparam int WH = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  logic [WH-1:0] hold_q, hold_d;
  logic          hold_max;
  assign hold_max = hold_q == WH'(MAX_HOLD - 1);
  assign keep     = bus.req[owner_q] && !(hold_max && pick_any);
  // hold counter restarts on every grant change and saturates while the owner is alone
  always_comb hold_d = (state_q == ST_GRANT && keep) ? (hold_max ? hold_q : hold_q + 1'b1) : '0;
  // hold counter register
  always_ff @(posedge clk) hold_q <= reset ? '0 : hold_d;
`else
  assign keep = bus.req[owner_q];
`endif
  // parameter sanity; constant once elaborated
  always_ff @(posedge clk) assert (N >= 2 && N <= 16 && MAX_HOLD >= 2);
  // state, owner and search pointer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end
  // next state: keep the owner, otherwise hand over to the winner, otherwise idle
  always_comb begin
    state_d = ST_IDLE;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    if (state_q == ST_GRANT && keep) state_d = ST_GRANT;
    else if (pick_any) begin
      state_d = ST_GRANT;
      owner_d = pick_idx;
      ptr_d   = wrap_inc(pick_idx);
    end
  end
  // outputs decode from registered state and owner only
  always_comb begin
    bus.busy     = state_q == ST_GRANT;
    bus.grant    = bus.busy ? N'(1) << owner_q : '0;
    bus.grant_id = owner_q;
  end
endmodule

// File: tb/tb_rr_hold_arbiter.sv
// tb_rr_hold_arbiter: directed checks of grant order, handover, hold limit and reset
module tb_rr_hold_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_assert = 0;
  int   n_fail = 0;
  rr_hold_arbiter_if #(.N(4)) bus ();
  rr_hold_arbiter #(.N(4), .MAX_HOLD(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [1:0] id_of(input logic [3:0] g);
    return g[3] ? 2'd3 : g[2] ? 2'd2 : g[1] ? 2'd1 : 2'd0;
  endfunction
  task automatic chk(input string tag, input logic [3:0] exp);
    n_assert++;
    assert (bus.grant === exp) else begin
      n_fail++;
      $error("FAIL %s grant observed=%b expected=%b", tag, bus.grant, exp);
    end
    n_assert++;
    assert (bus.busy === (|exp)) else begin
      n_fail++;
      $error("FAIL %s busy observed=%b expected=%b", tag, bus.busy, |exp);
    end
    if (exp != 4'b0000) begin
      n_assert++;
      assert (bus.grant_id === id_of(exp)) else begin
        n_fail++;
        $error("FAIL %s grant_id observed=%0d expected=%0d", tag, bus.grant_id, id_of(exp));
      end
    end
  endtask
  task automatic do_reset();
    reset   = 1'b1;
    bus.req = 4'b0000;
    tick();
    reset = 1'b0;
  endtask
  initial begin
    bus.req = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1_reset_hold", 4'b0000);
    end
    reset = 1'b0;
    tick();
    chk("t1_release", 4'b0001);
    do_reset();
    chk("t2_idle", 4'b0000);
    bus.req = 4'b1010;
    tick();
    chk("t2_first", 4'b0010);
    tick();
    chk("t2_hold_a", 4'b0010);
    tick();
    chk("t2_hold_b", 4'b0010);
    bus.req = 4'b1000;
    tick();
    chk("t2_handover", 4'b1000);
    do_reset();
    bus.req = 4'b1111;
    tick();
    chk("t3_g0", 4'b0001);
    bus.req = 4'b1110;
    tick();
    chk("t3_g1", 4'b0010);
    bus.req = 4'b1101;
    tick();
    chk("t3_g2", 4'b0100);
    bus.req = 4'b1011;
    tick();
    chk("t3_g3", 4'b1000);
    bus.req = 4'b0111;
    tick();
    chk("t3_wrap", 4'b0001);
    do_reset();
    bus.req = 4'b0011;
    for (int t = 1; t <= 12; t++) begin
      tick();
`ifdef RR_ARB_HOLD_LIMIT_EN
      chk("t4_hold_limit", (((t - 1) / 4) % 2 == 0) ? 4'b0001 : 4'b0010);
`else
      chk("t4_hold_forever", 4'b0001);
`endif
    end
    do_reset();
    bus.req = 4'b0100;
    for (int t = 0; t < 20; t++) begin
      tick();
      chk("t5_alone", 4'b0100);
    end
    reset = 1'b1;
    tick();
    chk("t6_reset_mid", 4'b0000);
    reset   = 1'b0;
    bus.req = 4'b1001;
    tick();
    chk("t6_ptr_reset", 4'b0001);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
